// File: rtl/ss_world_renderer.sv
// ss_world_renderer: world-map video stage.
//   Converts display-timing pixel coordinates into the tile address for the map
//   muxer video port. Pipelines the returned 2-bit tile code against BRAM read
//   latency and maps it to 12-bit RGB. Blanks the world layer for FADE_FRAMES
//   frames after every map change.
// Ports:
//   clk_75       - 75 MHz video clock, rising edge
//   reset        - asynchronous, active-low; clears all state
//   pixel_row    - display row (768+ is vertical blank)
//   pixel_column - display column
//   video_on     - visible-area flag aligned with the coordinates
//   map_id       - active map index from the muxer
//   vid_addr     - registered tile address {row[9:3], col[9:3]}
//   world_pixel  - tile code, valid BRAM_LAT cycles after vid_addr
//   vid_rgb      - registered RGB (zero when invisible or blanking)
//   vid_valid    - registered, video_on aligned with vid_rgb
//   fade_active  - registered, high while blanking after a map change
module ss_world_renderer #(
    parameter int unsigned BRAM_LAT    = 2,
    parameter int unsigned FADE_FRAMES = 30,
    parameter logic [11:0] COLOR0      = 12'h6AF,
    parameter logic [11:0] COLOR1      = 12'h852,
    parameter logic [11:0] COLOR2      = 12'hF00,
    parameter logic [11:0] COLOR3      = 12'hFFF
) (
    input  logic        clk_75,
    input  logic        reset,
    input  logic [11:0] pixel_row,
    input  logic [11:0] pixel_column,
    input  logic        video_on,
    input  logic [3:0]  map_id,
    output logic [13:0] vid_addr,
    input  logic [1:0]  world_pixel,
    output logic [11:0] vid_rgb,
    output logic        vid_valid,
    output logic        fade_active
);

    typedef enum logic [0:0] {StIdle, StBlank} state_e;

    localparam logic [7:0] FadeLast = 8'(FADE_FRAMES - 1);

    state_e          state_q, state_d;
    logic [7:0]      fade_cnt_q, fade_cnt_d;
    logic [3:0]      map_prev_q, map_prev_d;
    logic [13:0]     vid_addr_q, vid_addr_d;
    logic [BRAM_LAT:0] von_q, von_d;
    logic [11:0]     vid_rgb_q, vid_rgb_d;
    logic            vid_valid_q, vid_valid_d;
    logic            fade_active_q, fade_active_d;

    logic frame_tick;
    logic chg;

    // First cycle of vertical blank; exactly once per frame.
    assign frame_tick = (pixel_row == 12'd768) && (pixel_column == 12'd0);
    assign chg        = (map_id != map_prev_q);

    // Address stage and video_on delay line (1 + BRAM_LAT deep, so the tap
    // lines up with world_pixel).
    always_comb begin
        vid_addr_d = {pixel_row[9:3], pixel_column[9:3]};
        von_d      = {von_q[BRAM_LAT-1:0], video_on};
        map_prev_d = map_id;
    end

    // Fade FSM. A map change always restarts the count, even on the final tick.
    always_comb begin
        state_d    = state_q;
        fade_cnt_d = fade_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (chg) begin
                    state_d    = StBlank;
                    fade_cnt_d = 8'd0;
                end
            end
            StBlank: begin
                if (chg) begin
                    fade_cnt_d = 8'd0;
                end else if (frame_tick) begin
                    if (fade_cnt_q == FadeLast) begin
                        state_d    = StIdle;
                        fade_cnt_d = 8'd0;
                    end else begin
                        fade_cnt_d = fade_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Colour stage. Blanking uses the next state so that vid_rgb drops on the
    // same edge fade_active rises, including pixels already in flight.
    always_comb begin
        vid_rgb_d     = 12'h000;
        vid_valid_d   = von_q[BRAM_LAT];
        fade_active_d = (state_d == StBlank);
        if (von_q[BRAM_LAT] && (state_d != StBlank)) begin
            case (world_pixel)
                2'b00:   vid_rgb_d = COLOR0;
                2'b01:   vid_rgb_d = COLOR1;
                2'b10:   vid_rgb_d = COLOR2;
                default: vid_rgb_d = COLOR3;
            endcase
        end
    end

    always_ff @(posedge clk_75 or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            fade_cnt_q    <= 8'd0;
            map_prev_q    <= 4'd0;
            vid_addr_q    <= 14'd0;
            von_q         <= '0;
            vid_rgb_q     <= 12'h000;
            vid_valid_q   <= 1'b0;
            fade_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fade_cnt_q    <= fade_cnt_d;
            map_prev_q    <= map_prev_d;
            vid_addr_q    <= vid_addr_d;
            von_q         <= von_d;
            vid_rgb_q     <= vid_rgb_d;
            vid_valid_q   <= vid_valid_d;
            fade_active_q <= fade_active_d;
        end
    end

    assign vid_addr    = vid_addr_q;
    assign vid_rgb     = vid_rgb_q;
    assign vid_valid   = vid_valid_q;
    assign fade_active = fade_active_q;

endmodule

// File: tb/tb_ss_world_renderer.sv
// Directed bench for ss_world_renderer at default parameters. A two-stage
// register pipeline stands in for the BRAM; its tile code is the low two
// address bits (so 14'h619 returns 2'b01).
module tb_ss_world_renderer;

    logic        clk_75;
    logic        reset;
    logic [11:0] pixel_row;
    logic [11:0] pixel_column;
    logic        video_on;
    logic [3:0]  map_id;
    logic [13:0] vid_addr;
    logic [1:0]  world_pixel;
    logic [11:0] vid_rgb;
    logic        vid_valid;
    logic        fade_active;

    int checks = 0;
    int errors = 0;

    logic [11:0] colors [4] = '{12'h6AF, 12'h852, 12'hF00, 12'hFFF};

    ss_world_renderer dut (
        .clk_75      (clk_75),
        .reset       (reset),
        .pixel_row   (pixel_row),
        .pixel_column(pixel_column),
        .video_on    (video_on),
        .map_id      (map_id),
        .vid_addr    (vid_addr),
        .world_pixel (world_pixel),
        .vid_rgb     (vid_rgb),
        .vid_valid   (vid_valid),
        .fade_active (fade_active)
    );

    initial begin
        clk_75 = 1'b0;
        forever #5 clk_75 = ~clk_75;
    end

    // BRAM model: 2-cycle read latency.
    logic [13:0] addr_p1, addr_p2;
    always_ff @(posedge clk_75) begin
        addr_p1 <= vid_addr;
        addr_p2 <= addr_p1;
    end
    assign world_pixel = addr_p2[1:0];

    task automatic step();
        @(posedge clk_75);
        #1;
    endtask

    task automatic drive(input logic [11:0] r, input logic [11:0] c, input logic v);
        pixel_row    = r;
        pixel_column = c;
        video_on     = v;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        map_id = 4'd0;
        drive(12'd0, 12'd0, 1'b0);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(12'($urandom), 12'($urandom), 1'($urandom));
            map_id = 4'($urandom);
            step();
            checks++;
            if ({vid_addr, vid_rgb, vid_valid, fade_active} !== 28'd0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d got addr=%h rgb=%h valid=%b fade=%b exp all 0",
                         i, vid_addr, vid_rgb, vid_valid, fade_active);
            end
        end
        map_id = 4'd0;
        drive(12'd0, 12'd8, 1'b1);
        reset = 1'b1;
        for (int f = 0; f < 3; f++) begin
            step();
            step();
            drive(12'd768, 12'd0, 1'b0);
            step();
            drive(12'd0, 12'd8, 1'b1);
            checks++;
            if (fade_active !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_fade frame%0d got %b exp 0", f, fade_active);
            end
        end
    endtask

    task automatic test_address();
        drive(12'd100, 12'd200, 1'b0);
        step();
        checks++;
        if (vid_addr !== 14'h0619) begin
            errors++;
            $display("FAIL addr_100_200 got %h exp 0619", vid_addr);
        end
        drive(12'd767, 12'd1023, 1'b0);
        step();
        checks++;
        if (vid_addr !== 14'h2FFF) begin
            errors++;
            $display("FAIL addr_767_1023 got %h exp 2fff", vid_addr);
        end
    endtask

    task automatic test_latency();
        logic [11:0] exp_rgb;
        logic        exp_valid;
        drive(12'd0, 12'd0, 1'b0);
        for (int i = 0; i < 5; i++) step();
        drive(12'd100, 12'd200, 1'b1);
        for (int n = 1; n <= 5; n++) begin
            step();
            if (n == 1) drive(12'd0, 12'd0, 1'b0);
            exp_valid = (n == 4);
            exp_rgb   = (n == 4) ? 12'h852 : 12'h000;
            checks++;
            if (vid_valid !== exp_valid || vid_rgb !== exp_rgb) begin
                errors++;
                $display("FAIL latency_von1 cyc%0d got rgb=%h valid=%b exp rgb=%h valid=%b",
                         n, vid_rgb, vid_valid, exp_rgb, exp_valid);
            end
        end
        drive(12'd100, 12'd200, 1'b0);
        for (int n = 1; n <= 4; n++) begin
            step();
            if (n == 1) drive(12'd0, 12'd0, 1'b0);
        end
        checks++;
        if (vid_valid !== 1'b0 || vid_rgb !== 12'h000) begin
            errors++;
            $display("FAIL latency_von0 got rgb=%h valid=%b exp rgb=000 valid=0", vid_rgb, vid_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 1; n <= 8; n++) begin
            if (n <= 4) drive(12'd0, 12'((n - 1) * 8), 1'b1);
            else        drive(12'd0, 12'd0, 1'b0);
            step();
            if (n >= 4 && n <= 7) begin
                checks++;
                if (vid_rgb !== colors[n-4] || vid_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_code%0d got rgb=%h valid=%b exp rgb=%h valid=1",
                             n - 4, vid_rgb, vid_valid, colors[n-4]);
                end
            end
        end
    endtask

    task automatic test_map_change();
        drive(12'd0, 12'd8, 1'b1);
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (vid_rgb !== 12'h852 || vid_valid !== 1'b1 || fade_active !== 1'b0) begin
            errors++;
            $display("FAIL pre_fade got rgb=%h valid=%b fade=%b exp rgb=852 valid=1 fade=0",
                     vid_rgb, vid_valid, fade_active);
        end
        map_id = 4'd2;
        step();
        checks++;
        if (fade_active !== 1'b1 || vid_rgb !== 12'h000 || vid_valid !== 1'b1) begin
            errors++;
            $display("FAIL fade_start got fade=%b rgb=%h valid=%b exp fade=1 rgb=000 valid=1",
                     fade_active, vid_rgb, vid_valid);
        end
        for (int t = 1; t <= 30; t++) begin
            drive(12'd0, 12'd8, 1'b1);
            step();
            step();
            if (t == 1) begin
                checks++;
                if (vid_rgb !== 12'h000 || vid_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL fade_blank got rgb=%h valid=%b exp rgb=000 valid=1",
                             vid_rgb, vid_valid);
                end
            end
            drive(12'd768, 12'd0, 1'b0);
            step();
            checks++;
            if (fade_active !== (t < 30)) begin
                errors++;
                $display("FAIL fade_tick%0d got %b exp %b", t, fade_active, (t < 30));
            end
        end
        drive(12'd0, 12'd8, 1'b1);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (vid_rgb !== 12'h852 || vid_valid !== 1'b1 || fade_active !== 1'b0) begin
            errors++;
            $display("FAIL post_fade got rgb=%h valid=%b fade=%b exp rgb=852 valid=1 fade=0",
                     vid_rgb, vid_valid, fade_active);
        end
    endtask

    // Reset with map 2 present: release is seen as a change from map 0.
    task automatic test_change_mid_fade();
        reset  = 1'b0;
        map_id = 4'd2;
        step();
        reset = 1'b1;
        drive(12'd0, 12'd8, 1'b1);
        step();
        checks++;
        if (fade_active !== 1'b1) begin
            errors++;
            $display("FAIL mid_fade_start got %b exp 1", fade_active);
        end
        for (int t = 1; t <= 40; t++) begin
            drive(12'd0, 12'd8, 1'b1);
            step();
            step();
            drive(12'd768, 12'd0, 1'b0);
            if (t == 10) map_id = 4'd3;
            step();
            checks++;
            if (fade_active !== (t < 40)) begin
                errors++;
                $display("FAIL mid_fade_tick%0d got %b exp %b", t, fade_active, (t < 40));
            end
        end
    endtask

    task automatic test_chg_on_last_tick();
        drive(12'd0, 12'd8, 1'b1);
        map_id = 4'd6;
        step();
        for (int t = 1; t <= 60; t++) begin
            drive(12'd0, 12'd8, 1'b1);
            step();
            step();
            drive(12'd768, 12'd0, 1'b0);
            if (t == 30) map_id = 4'd7;
            step();
            checks++;
            if (fade_active !== (t < 60)) begin
                errors++;
                $display("FAIL last_tick_chg_tick%0d got %b exp %b", t, fade_active, (t < 60));
            end
        end
    endtask

    task automatic test_reset_mid_fade();
        drive(12'd0, 12'd8, 1'b1);
        map_id = 4'd4;
        step();
        for (int t = 1; t <= 4; t++) begin
            drive(12'd0, 12'd8, 1'b1);
            step();
            step();
            drive(12'd768, 12'd0, 1'b0);
            step();
            checks++;
            if (fade_active !== 1'b1) begin
                errors++;
                $display("FAIL rst_fade_tick%0d got %b exp 1", t, fade_active);
            end
        end
        drive(12'd768, 12'd0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (fade_active !== 1'b0 || vid_rgb !== 12'h000 || vid_valid !== 1'b0 ||
            vid_addr !== 14'd0) begin
            errors++;
            $display("FAIL async_reset got fade=%b rgb=%h valid=%b addr=%h exp all 0",
                     fade_active, vid_rgb, vid_valid, vid_addr);
        end
        step();
        reset = 1'b1;
        drive(12'd0, 12'd8, 1'b1);
        #1;
        checks++;
        if (fade_active !== 1'b0) begin
            errors++;
            $display("FAIL rst_release_pre got %b exp 0", fade_active);
        end
        step();
        checks++;
        if (fade_active !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_refade got %b exp 1", fade_active);
        end
    endtask

    initial begin
        test_reset();
        test_address();
        test_latency();
        test_back_to_back();
        test_map_change();
        test_change_mid_fade();
        test_chg_on_last_tick();
        test_reset_mid_fade();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
